// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the write-back stage and integer register file:
// datapath/register-address defaults, load funct3 encodings, write-back
// source select values and a small helper for load signedness.
//
// No ports (package).
// ---------------------------------------------------------------------------
package wb_pkg;

   // Datapath width and register file geometry defaults
   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int REG_AW = $clog2(NREG);

   // Load funct3 encodings; 011, 110 and 111 are undefined and behave as LW
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Write-back source select
   localparam logic WB_SEL_ALU = 1'b0;
   localparam logic WB_SEL_LD  = 1'b1;

   // funct3[2] marks the zero-extending load variants (LBU/LHU)
   function automatic logic is_unsigned_load(input logic [2:0] funct3);
      return funct3[2];
   endfunction

endpackage

// File: rtl/wb_regfile_load_ext.sv
// ---------------------------------------------------------------------------
// load_ext
// Formats a raw aligned load word into the architectural load result:
// byte/halfword extraction by byte offset followed by sign or zero extension.
//
// Ports:
//   ld_funct3  in   3     load type (LB/LH/LW/LBU/LHU, undefined -> LW)
//   ld_offset  in   2     byte offset within the word (address[1:0])
//   ld_data    in   XLEN  raw aligned load word
//   ld_result  out  XLEN  formatted load value
// ---------------------------------------------------------------------------
module load_ext #(
   parameter int XLEN = wb_pkg::XLEN
) (
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_offset,
   input  logic [XLEN-1:0] ld_data,
   output logic [XLEN-1:0] ld_result
);
   import wb_pkg::*;

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        zero_ext;

   // Pick the addressed byte and halfword out of the low 32 bits of the
   // word. Halfword selection only looks at offset[1]; a misaligned
   // halfword offset simply lands on the containing aligned halfword.
   always_comb begin
      byte_sel = ld_data[7:0];
      case (ld_offset)
         2'd0: byte_sel = ld_data[7:0];
         2'd1: byte_sel = ld_data[15:8];
         2'd2: byte_sel = ld_data[23:16];
         2'd3: byte_sel = ld_data[31:24];
         default: byte_sel = ld_data[7:0];
      endcase
      half_sel = ld_offset[1] ? ld_data[31:16] : ld_data[15:0];
      zero_ext = is_unsigned_load(ld_funct3);
   end

   // Extend the selected field to XLEN. Anything that is not a byte or
   // halfword load (including the undefined encodings) passes the full
   // word through unchanged.
   always_comb begin
      ld_result = ld_data;
      case (ld_funct3)
         F3_LB, F3_LBU:
            ld_result = {{(XLEN-8){byte_sel[7] & ~zero_ext}}, byte_sel};
         F3_LH, F3_LHU:
            ld_result = {{(XLEN-16){half_sel[15] & ~zero_ext}}, half_sel};
         default:
            ld_result = ld_data;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Write-back end of the pipeline: selects the ALU result or the formatted
// load value, commits it into a NREG x XLEN integer register file (x0 is
// hard-wired to zero) and serves two combinational read ports.
//
// Build option: define WB_BYPASS_EN to make a read of the register being
// committed this cycle return the new value (write-through). Without it a
// read in the commit cycle returns the old contents.
//
// Ports:
//   clk        in   1     clock, all state changes on rising edge
//   rst        in   1     synchronous reset, active-low
//   wb_en      in   1     commit write-back this cycle
//   wb_sel     in   1     0 = ALU result, 1 = load data
//   wb_rd      in   AW    destination register
//   ld_funct3  in   3     load type
//   ld_offset  in   2     byte offset of the load
//   alu_out    in   XLEN  ALU result
//   ld_data    in   XLEN  raw aligned load word
//   rs1_addr   in   AW    read port 1 address
//   rs2_addr   in   AW    read port 2 address
//   rs1_data   out  XLEN  read port 1 data (combinational)
//   rs2_data   out  XLEN  read port 2 data (combinational)
//   wb_data    out  XLEN  formatted write-back value (combinational)
// ---------------------------------------------------------------------------
module wb_regfile #(
   parameter  int XLEN = wb_pkg::XLEN,
   parameter  int NREG = wb_pkg::NREG,
   localparam int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_en,
   input  logic            wb_sel,
   input  logic [AW-1:0]   wb_rd,
   input  logic [2:0]      ld_funct3,
   input  logic [1:0]      ld_offset,
   input  logic [XLEN-1:0] alu_out,
   input  logic [XLEN-1:0] ld_data,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic [XLEN-1:0] wb_data
);
   import wb_pkg::*;

   logic [XLEN-1:0] ld_result;
   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic            commit;
   logic            bypass_rs1;
   logic            bypass_rs2;

   load_ext #(
      .XLEN (XLEN)
   ) u_load_ext (
      .ld_funct3 (ld_funct3),
      .ld_offset (ld_offset),
      .ld_data   (ld_data),
      .ld_result (ld_result)
   );

   // Write-back source select. Driven every cycle regardless of wb_en so
   // the forwarding network always sees the value this stage would write.
   always_comb begin
      wb_data = alu_out;
      if (wb_sel == WB_SEL_LD) begin
         wb_data = ld_result;
      end
   end

   // A commit only happens for a non-zero destination; writes aimed at x0
   // are dropped here so x0 is never stored.
   always_comb begin
      commit = wb_en && (wb_rd != '0);
   end

   // Next-state of the array: hold everything, update the one destination.
   always_comb begin
      regs_d = regs_q;
      if (commit) begin
         regs_d[wb_rd] = wb_data;
      end
   end

   // Register array. Reset wins over a write in the same edge, so an
   // in-flight commit coinciding with reset is discarded.
   always_ff @(posedge clk) begin
      if (!rst) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   // Same-cycle write-through detection, per port. Suppressed while reset
   // is asserted because that edge will not actually commit, and never
   // fires for x0 because commit already excludes it.
`ifdef WB_BYPASS_EN
   always_comb begin
      bypass_rs1 = rst && commit && (rs1_addr == wb_rd);
      bypass_rs2 = rst && commit && (rs2_addr == wb_rd);
   end
`else
   always_comb begin
      bypass_rs1 = 1'b0;
      bypass_rs2 = 1'b0;
   end
`endif

   // Read ports: x0 is forced to zero, otherwise either the bypassed
   // write-back value or the stored contents.
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1_addr != '0) begin
         rs1_data = bypass_rs1 ? wb_data : regs_q[rs1_addr];
      end
      if (rs2_addr != '0) begin
         rs2_data = bypass_rs2 ? wb_data : regs_q[rs2_addr];
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
// Directed testbench for wb_regfile. Inputs change on the falling edge,
// combinational outputs are checked 1 ns later (before the next rising
// edge commits), so each step sees the "same cycle" view of the design.
// Expected values are hand-computed; bypass-dependent expectations follow
// the WB_BYPASS_EN define.
// ---------------------------------------------------------------------------
module tb_wb_regfile;
   import wb_pkg::*;

   logic        clk;
   logic        rst;
   logic        wb_en;
   logic        wb_sel;
   logic [4:0]  wb_rd;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_offset;
   logic [31:0] alu_out;
   logic [31:0] ld_data;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] wb_data;

   int compared;
   int mismatched;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   wb_regfile dut (
      .clk       (clk),
      .rst       (rst),
      .wb_en     (wb_en),
      .wb_sel    (wb_sel),
      .wb_rd     (wb_rd),
      .ld_funct3 (ld_funct3),
      .ld_offset (ld_offset),
      .alu_out   (alu_out),
      .ld_data   (ld_data),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .wb_data   (wb_data)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle's worth of inputs on the falling edge, then settle.
   task automatic applyStimulus(input logic r, input logic en, input logic sel,
                                input logic [4:0] rd, input logic [2:0] f3,
                                input logic [1:0] off, input logic [31:0] alu,
                                input logic [31:0] ld, input logic [4:0] a1,
                                input logic [4:0] a2);
      @(negedge clk);
      rst       = r;
      wb_en     = en;
      wb_sel    = sel;
      wb_rd     = rd;
      ld_funct3 = f3;
      ld_offset = off;
      alu_out   = alu;
      ld_data   = ld;
      rs1_addr  = a1;
      rs2_addr  = a2;
      #1;
   endtask

   // One comparison: count it, and on mismatch print a FAIL line and raise $error.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
         $error("[TB] %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   localparam logic [31:0] LDW = 32'h80FF7F01;

   initial begin
      compared   = 0;
      mismatched = 0;
      rst = 1'b0; wb_en = 1'b0; wb_sel = 1'b0; wb_rd = '0; ld_funct3 = '0;
      ld_offset = '0; alu_out = '0; ld_data = '0; rs1_addr = '0; rs2_addr = '0;

      // Reset held two cycles with a write pending; bypass must stay off
      applyStimulus(1'b0, 1'b1, WB_SEL_ALU, 5'd5, F3_LW, 2'd0, 32'h1234, 32'h0, 5'd5, 5'd5);
      checkOutput("rst_wbdata", wb_data, 32'h0000_1234);
      checkOutput("rst_rd1_c0", rs1_data, 32'h0);
      applyStimulus(1'b0, 1'b1, WB_SEL_ALU, 5'd5, F3_LW, 2'd0, 32'h1234, 32'h0, 5'd5, 5'd5);
      checkOutput("rst_rd1_c1", rs1_data, 32'h0);
      applyStimulus(1'b1, 1'b0, WB_SEL_ALU, 5'd0, F3_LW, 2'd0, 32'h0, 32'h0, 5'd5, 5'd5);
      checkOutput("post_rst_rd1", rs1_data, 32'h0);
      checkOutput("post_rst_rd2", rs2_data, 32'h0);

      // ALU write to x7, same-cycle then next-cycle reads
      applyStimulus(1'b1, 1'b1, WB_SEL_ALU, 5'd7, F3_LW, 2'd0, 32'hDEADBEEF, LDW, 5'd7, 5'd7);
      checkOutput("alu_wbdata", wb_data, 32'hDEADBEEF);
      checkOutput("alu_same_rd1", rs1_data, BYP ? 32'hDEADBEEF : 32'h0);
      checkOutput("alu_same_rd2", rs2_data, BYP ? 32'hDEADBEEF : 32'h0);
      applyStimulus(1'b1, 1'b0, WB_SEL_ALU, 5'd7, F3_LW, 2'd0, 32'h0, LDW, 5'd7, 5'd7);
      checkOutput("alu_next_rd1", rs1_data, 32'hDEADBEEF);
      checkOutput("alu_next_rd2", rs2_data, 32'hDEADBEEF);

      // Load formatting of 0x80FF7F01 (bytes 3..0 = 80 FF 7F 01)
      applyStimulus(1'b1, 1'b0, WB_SEL_LD, 5'd0, F3_LB, 2'd3, 32'h0, LDW, 5'd0, 5'd0);
      checkOutput("ld_lb_off3", wb_data, 32'hFFFFFF80);
      applyStimulus(1'b1, 1'b0, WB_SEL_LD, 5'd0, F3_LBU, 2'd3, 32'h0, LDW, 5'd0, 5'd0);
      checkOutput("ld_lbu_off3", wb_data, 32'h00000080);
      applyStimulus(1'b1, 1'b0, WB_SEL_LD, 5'd0, F3_LB, 2'd1, 32'h0, LDW, 5'd0, 5'd0);
      checkOutput("ld_lb_off1", wb_data, 32'h0000007F);
      applyStimulus(1'b1, 1'b0, WB_SEL_LD, 5'd0, F3_LBU, 2'd2, 32'h0, LDW, 5'd0, 5'd0);
      checkOutput("ld_lbu_off2", wb_data, 32'h000000FF);
      applyStimulus(1'b1, 1'b0, WB_SEL_LD, 5'd0, F3_LH, 2'd2, 32'h0, LDW, 5'd0, 5'd0);
      checkOutput("ld_lh_off2", wb_data, 32'hFFFF80FF);
      applyStimulus(1'b1, 1'b0, WB_SEL_LD, 5'd0, F3_LH, 2'd3, 32'h0, LDW, 5'd0, 5'd0);
      checkOutput("ld_lh_off3", wb_data, 32'hFFFF80FF);
      applyStimulus(1'b1, 1'b0, WB_SEL_LD, 5'd0, F3_LHU, 2'd1, 32'h0, LDW, 5'd0, 5'd0);
      checkOutput("ld_lhu_off1", wb_data, 32'h00007F01);
      applyStimulus(1'b1, 1'b0, WB_SEL_LD, 5'd0, F3_LHU, 2'd2, 32'h0, LDW, 5'd0, 5'd0);
      checkOutput("ld_lhu_off2", wb_data, 32'h000080FF);
      applyStimulus(1'b1, 1'b0, WB_SEL_LD, 5'd0, F3_LW, 2'd3, 32'h0, LDW, 5'd0, 5'd0);
      checkOutput("ld_lw", wb_data, 32'h80FF7F01);
      applyStimulus(1'b1, 1'b0, WB_SEL_LD, 5'd0, 3'b111, 2'd1, 32'h0, LDW, 5'd0, 5'd0);
      checkOutput("ld_f3_111", wb_data, 32'h80FF7F01);
      applyStimulus(1'b1, 1'b0, WB_SEL_LD, 5'd0, 3'b011, 2'd0, 32'h0, LDW, 5'd0, 5'd0);
      checkOutput("ld_f3_011", wb_data, 32'h80FF7F01);

      // Commit a formatted load into x10 and read it back
      applyStimulus(1'b1, 1'b1, WB_SEL_LD, 5'd10, F3_LB, 2'd3, 32'h0, LDW, 5'd0, 5'd0);
      applyStimulus(1'b1, 1'b0, WB_SEL_ALU, 5'd0, F3_LW, 2'd0, 32'h0, 32'h0, 5'd10, 5'd0);
      checkOutput("ld_commit_x10", rs1_data, 32'hFFFFFF80);

      // x0 protection, same cycle and after the edge
      applyStimulus(1'b1, 1'b1, WB_SEL_ALU, 5'd0, F3_LW, 2'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd7);
      checkOutput("x0_same_rd1", rs1_data, 32'h0);
      checkOutput("x0_same_rd2_x7", rs2_data, 32'hDEADBEEF);
      applyStimulus(1'b1, 1'b0, WB_SEL_ALU, 5'd0, F3_LW, 2'd0, 32'h0, 32'h0, 5'd0, 5'd0);
      checkOutput("x0_next_rd1", rs1_data, 32'h0);
      checkOutput("x0_next_rd2", rs2_data, 32'h0);

      // Fill x1..x31 with their index
      for (int i = 1; i < 32; i++) begin
         applyStimulus(1'b1, 1'b1, WB_SEL_ALU, 5'(i), F3_LW, 2'd0, 32'(i), 32'h0, 5'd0, 5'd0);
      end
      applyStimulus(1'b1, 1'b0, WB_SEL_ALU, 5'd0, F3_LW, 2'd0, 32'h0, 32'h0, 5'd31, 5'd1);
      checkOutput("fill_x31", rs1_data, 32'd31);
      checkOutput("fill_x1", rs2_data, 32'd1);

      // Reset coincident with a write of x3 <- 0xAA; no bypass while in reset
      applyStimulus(1'b0, 1'b1, WB_SEL_ALU, 5'd3, F3_LW, 2'd0, 32'hAA, 32'h0, 5'd3, 5'd4);
      checkOutput("midrst_same_x3", rs1_data, 32'd3);
      checkOutput("midrst_same_x4", rs2_data, 32'd4);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, 1'b0, WB_SEL_ALU, 5'd0, F3_LW, 2'd0, 32'h0, 32'h0,
                       5'(i), 5'(31 - i));
         checkOutput($sformatf("midrst_rd1_x%0d", i), rs1_data, 32'h0);
         checkOutput($sformatf("midrst_rd2_x%0d", 31 - i), rs2_data, 32'h0);
      end

      // Disabled write: x9 keeps its value, wb_data still follows alu_out
      applyStimulus(1'b1, 1'b1, WB_SEL_ALU, 5'd9, F3_LW, 2'd0, 32'h11, 32'h0, 5'd0, 5'd0);
      applyStimulus(1'b1, 1'b0, WB_SEL_ALU, 5'd9, F3_LW, 2'd0, 32'h55, 32'h0, 5'd9, 5'd9);
      checkOutput("dis_wbdata", wb_data, 32'h55);
      checkOutput("dis_same_x9", rs1_data, 32'h11);
      applyStimulus(1'b1, 1'b0, WB_SEL_ALU, 5'd0, F3_LW, 2'd0, 32'h0, 32'h0, 5'd9, 5'd0);
      checkOutput("dis_next_x9", rs1_data, 32'h11);

      // Per-port bypass: only the port addressing wb_rd sees the new value
      applyStimulus(1'b1, 1'b1, WB_SEL_ALU, 5'd12, F3_LW, 2'd0, 32'hCAFEF00D, 32'h0, 5'd12, 5'd9);
      checkOutput("byp_port1_x12", rs1_data, BYP ? 32'hCAFEF00D : 32'h0);
      checkOutput("byp_port2_x9", rs2_data, 32'h11);
      applyStimulus(1'b1, 1'b0, WB_SEL_ALU, 5'd0, F3_LW, 2'd0, 32'h0, 32'h0, 5'd9, 5'd12);
      checkOutput("byp_next_x12", rs2_data, 32'hCAFEF00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Safety net against a stuck run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
